// File: rtl/mbox_wr_queue_if.sv
// mbox_wr_queue_if: WISHBONE slave queueing mailbox words in a small FIFO and
// serialising the selected byte lanes, one per cycle, into the MAILBOX byte port.
`default_nettype none

module mbox_wr_queue_if #(
   parameter int WB_DW     = 32,
   parameter int DEPTH     = 4,
   parameter int DEPTH_W   = 2,
   parameter int MSB_FIRST = 0
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic               wb_we_i,
   input  logic               wb_adr_i,
   input  logic [WB_DW/8-1:0] wb_sel_i,
   input  logic [WB_DW-1:0]   wb_dat_i,
   output logic [WB_DW-1:0]   wb_dat_o,
   output logic               wb_ack_o,
   output logic               mbox_wr_o,
   output logic [7:0]         mbox_do_o,
   input  logic               mbox_full_i,
   input  logic               mbox_afull_i,
   output logic               q_empty_o
);

   localparam int NB = WB_DW / 8;
   localparam int LW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [DEPTH_W:0]   LVL_ONE  = (DEPTH_W+1)'(1);
   localparam logic [DEPTH_W:0]   LVL_FULL = (DEPTH_W+1)'(DEPTH);
   localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [DEPTH_W:0]   level_q, level_d;
   logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WB_DW-1:0]   data_q, data_d;
   logic [NB-1:0]      rem_q, rem_d;
   logic [7:0]         do_q, do_d;
   logic               ack_q, ack_d;
   logic [WB_DW-1:0]   dat_q, dat_d;

   logic [WB_DW-1:0]   mem_dat [DEPTH];
   logic [NB-1:0]      mem_sel [DEPTH];

   logic               req, wr_data, rd_req, flush, push, pop, stall;
   logic               fifo_full, q_empty, mbox_wr;
   logic [NB-1:0]      rem_nxt;
   logic [31:0]        status;

   // Index of the next lane to send among the set bits of m, in the configured order.
   function automatic logic [LW-1:0] pick_lane(input logic [NB-1:0] m);
      pick_lane = '0;
      for (int i = 0; i < NB; i++) begin
         if (MSB_FIRST == 0) begin
            if (m[NB-1-i]) pick_lane = LW'(NB-1-i);
         end else begin
            if (m[i]) pick_lane = LW'(i);
         end
      end
   endfunction

   function automatic logic [7:0] lane_byte(input logic [WB_DW-1:0] d, input logic [LW-1:0] l);
      lane_byte = d[int'(l)*8 +: 8];
   endfunction

   always_comb begin
      req       = wb_cyc_i & wb_stb_i & ~ack_q;
      wr_data   = req & wb_we_i & ~wb_adr_i;
      rd_req    = req & ~wb_we_i;
      flush     = req & wb_we_i & wb_adr_i & wb_dat_i[0];
      fifo_full = (level_q == LVL_FULL);
      q_empty   = (level_q == '0) && (state_q == S_IDLE);
      rem_nxt   = rem_q & ~(NB'(1) << pick_lane(rem_q));

      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      do_d    = do_q;
      pop     = 1'b0;
      mbox_wr = 1'b0;

      case (state_q)
         S_IDLE: if (level_q != '0) pop = 1'b1;
         S_SEND: begin
            if (!mbox_full_i) begin
               mbox_wr = 1'b1;
               if (rem_nxt != '0) begin
                  rem_d = rem_nxt;
                  do_d  = lane_byte(data_q, pick_lane(rem_nxt));
               end else if (level_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Loading straight from the FIFO head keeps back-to-back words bubble-free.
      if (pop) begin
         state_d = S_SEND;
         data_d  = mem_dat[rd_ptr_q];
         rem_d   = mem_sel[rd_ptr_q];
         do_d    = lane_byte(mem_dat[rd_ptr_q], pick_lane(mem_sel[rd_ptr_q]));
      end

      // A pop in the same cycle frees the slot, so a write to a full FIFO is taken then.
      stall  = wr_data & fifo_full & ~pop;
      push   = wr_data & (wb_sel_i != '0) & ~stall;
      ack_d  = req & ~stall;
      status = {16'd0, 12'(level_q), fifo_full, q_empty, mbox_afull_i, mbox_full_i};
      dat_d  = rd_req ? WB_DW'(status) : dat_q;

      level_d  = level_q;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      if (flush) begin
         level_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         state_d  = S_IDLE;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q  <= S_IDLE;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         data_q   <= '0;
         rem_q    <= '0;
         do_q     <= '0;
         ack_q    <= 1'b0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         data_q   <= data_d;
         rem_q    <= rem_d;
         do_q     <= do_d;
         ack_q    <= ack_d;
         dat_q    <= dat_d;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem_dat[wr_ptr_q] <= wb_dat_i;
         mem_sel[wr_ptr_q] <= wb_sel_i;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_dat_o  = dat_q;
   assign mbox_wr_o = mbox_wr;
   assign mbox_do_o = do_q;
   assign q_empty_o = q_empty;

endmodule

`default_nettype wire
